// File: rtl/ltc2333_array_reader.sv
// Parallel LTC2333 frame reader: CNV/SCKI sequencing, per-device capture,
// double-buffered channel-major result stream with overflow counting.
module ltc2333_array_reader #(
    parameter int N_ADC       = 8,
    parameter int N_CH        = 8,
    parameter int CLK_DIV     = 2,
    parameter int CNV_HIGH    = 4,
    parameter int CONV_CYCLES = 50
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                start,
    input  logic                continuous,
    input  logic [31:0]         period,
    input  logic [3*N_CH-1:0]   softspan,
    output logic                cnv,
    output logic                scki,
    output logic                sdi,
    input  logic [N_ADC-1:0]    scko,
    input  logic [N_ADC-1:0]    sdo,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic [31:0]         m_tdata,
    output logic                m_tlast,
    output logic [15:0]         overflow_cnt,
    output logic                active
);

    localparam int TOTAL = 24 * N_CH;
    localparam int SSW   = 3 * N_CH;
    localparam int DW    = $clog2(2 * CLK_DIV);
    localparam int BW    = $clog2(TOTAL + 1);
    localparam int AW    = (N_ADC > 1) ? $clog2(N_ADC) : 1;
    localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {
        IDLE, CNV_HI, CONVERT, SHIFT, SETTLE, COMMIT
    } state_t;

    state_t state, state_nx;

    logic [31:0]    cnt;
    logic [31:0]    per_cnt;
    logic [DW-1:0]  div_cnt;
    logic [BW-1:0]  bit_cnt;
    logic [SSW-1:0] ss_sh;
    logic           go;
    logic           div_end;
    logic           shift_done;
    logic           frame_go;
    logic           shift_go;

    assign div_end    = (div_cnt == DW'(2 * CLK_DIV - 1));
    assign shift_done = div_end && (bit_cnt == BW'(TOTAL - 1));
    assign go         = start || (continuous && (per_cnt >= period));
    assign frame_go   = (state == IDLE) && (state_nx == CNV_HI);
    assign shift_go   = (state == CONVERT) && (state_nx == SHIFT);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (go) state_nx = CNV_HI;
            CNV_HI:  if (cnt == 32'(CNV_HIGH - 1)) state_nx = CONVERT;
            CONVERT: if (cnt == 32'(CONV_CYCLES - 1)) state_nx = SHIFT;
            SHIFT:   if (shift_done) state_nx = SETTLE;
            SETTLE:  if (cnt == 32'd3) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt     <= '0;
            per_cnt <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            ss_sh   <= '0;
        end else begin
            cnt <= (state_nx != state) ? 32'd0 : cnt + 32'd1;
            if (frame_go) begin
                per_cnt <= '0;
                ss_sh   <= softspan;
            end else if (per_cnt != '1) begin
                per_cnt <= per_cnt + 32'd1;
            end
            if (state == SHIFT) begin
                div_cnt <= div_end ? '0 : div_cnt + DW'(1);
                if (div_end) begin
                    bit_cnt <= bit_cnt + BW'(1);
                    ss_sh   <= ss_sh << 1;
                end
            end else begin
                div_cnt <= '0;
                bit_cnt <= '0;
            end
        end
    end

    assign cnv    = (state == CNV_HI);
    assign active = (state != IDLE);
    assign scki   = (state == SHIFT) && (div_cnt >= DW'(CLK_DIV));
    assign sdi    = (state == SHIFT) && ss_sh[SSW-1];

    logic [N_ADC-1:0] sck_s1, sck_s2, sck_s3;
    logic [N_ADC-1:0] sdo_s1, sdo_s2;
    logic [N_ADC-1:0] rise;
    logic             cap_en;
    logic [TOTAL-1:0] cap  [N_ADC];
    logic [BW-1:0]    cidx [N_ADC];

    assign rise   = sck_s2 & ~sck_s3;
    assign cap_en = (state == SHIFT) || (state == SETTLE);

    // Each device gets its own write pointer so short frames leave trailing zeros.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            sck_s1 <= '0;
            sck_s2 <= '0;
            sck_s3 <= '0;
            sdo_s1 <= '0;
            sdo_s2 <= '0;
            for (int i = 0; i < N_ADC; i++) begin
                cap[i]  <= '0;
                cidx[i] <= '0;
            end
        end else begin
            sck_s1 <= scko;
            sck_s2 <= sck_s1;
            sck_s3 <= sck_s2;
            sdo_s1 <= sdo;
            sdo_s2 <= sdo_s1;
            for (int i = 0; i < N_ADC; i++) begin
                if (shift_go) begin
                    cap[i]  <= '0;
                    cidx[i] <= '0;
                end else if (cap_en && rise[i] && cidx[i] != BW'(TOTAL)) begin
                    cap[i][BW'(TOTAL - 1) - cidx[i]] <= sdo_s2[i];
                    cidx[i] <= cidx[i] + BW'(1);
                end
            end
        end
    end

    logic [TOTAL-1:0] obuf [N_ADC];
    logic             buf_full;
    logic [AW-1:0]    adc_idx;
    logic [CW-1:0]    ch_idx;
    logic [15:0]      ovf;
    logic             last;
    logic             last_adc;
    logic [TOTAL-1:0] row;
    logic [23:0]      word;

    assign last_adc = (adc_idx == AW'(N_ADC - 1));
    assign last     = last_adc && (ch_idx == CW'(N_CH - 1));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            buf_full <= 1'b0;
            adc_idx  <= '0;
            ch_idx   <= '0;
            ovf      <= '0;
            for (int i = 0; i < N_ADC; i++) obuf[i] <= '0;
        end else begin
            if (buf_full && m_tready) begin
                if (last) begin
                    buf_full <= 1'b0;
                    adc_idx  <= '0;
                    ch_idx   <= '0;
                end else if (last_adc) begin
                    adc_idx <= '0;
                    ch_idx  <= ch_idx + CW'(1);
                end else begin
                    adc_idx <= adc_idx + AW'(1);
                end
            end
            if (state == COMMIT) begin
                if (!buf_full) begin
                    for (int i = 0; i < N_ADC; i++) obuf[i] <= cap[i];
                    buf_full <= 1'b1;
                    adc_idx  <= '0;
                    ch_idx   <= '0;
                end else if (ovf != '1) begin
                    ovf <= ovf + 16'd1;
                end
            end
        end
    end

    // Channel 0 is the first word shifted in, so it sits at the top of the row.
    always_comb begin
        row  = '0;
        word = '0;
        for (int a = 0; a < N_ADC; a++)
            if (adc_idx == AW'(a)) row = obuf[a];
        for (int c = 0; c < N_CH; c++)
            if (ch_idx == CW'(c)) word = row[TOTAL-1-24*c -: 24];
    end

    assign m_tvalid     = buf_full;
    assign m_tlast      = buf_full && last;
    assign m_tdata      = buf_full ? {8'(adc_idx), word} : 32'd0;
    assign overflow_cnt = ovf;

endmodule

// File: tb/tb_ltc2333_array_reader.sv
// Directed bench for ltc2333_array_reader with a behavioural
// LTC2333 array model driving sdo from scki.
module tb_ltc2333_array_reader;

    localparam int N_ADC = 8;
    localparam int N_CH  = 8;
    localparam int TOTAL = 24 * N_CH;
    localparam int BEATS = N_ADC * N_CH;

    logic        tb_ACLK;
    logic        ARESET;
    logic        start;
    logic        continuous;
    logic [31:0] period;
    logic [23:0] softspan;
    logic        cnv;
    logic        scki;
    logic        sdi;
    logic [7:0]  scko;
    logic [7:0]  sdo;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic [15:0] overflow_cnt;
    logic        active;

    int n_cmp = 0;
    int n_bad = 0;
    int kbit = 0;
    int frame_tag = 0;

    ltc2333_array_reader #(
        .N_ADC(N_ADC), .N_CH(N_CH), .CLK_DIV(2),
        .CNV_HIGH(4), .CONV_CYCLES(50)
    ) dut (
        .ACLK(tb_ACLK), .ARESET(ARESET), .start(start),
        .continuous(continuous), .period(period),
        .softspan(softspan), .cnv(cnv), .scki(scki), .sdi(sdi),
        .scko(scko), .sdo(sdo), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .overflow_cnt(overflow_cnt), .active(active)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    function automatic logic [23:0] dev_word(input int a, input int c,
                                             input int f);
        return {a[3:0], c[3:0], f[3:0], 12'h0AB};
    endfunction

    function automatic logic dev_bit(input int a, input int k, input int f);
        logic [23:0] w;
        if (k >= TOTAL) return 1'b0;
        w = dev_word(a, k / 24, f);
        return w[23 - (k % 24)];
    endfunction

    // Device model: echo scki, advance one bit per falling edge.
    assign scko = {N_ADC{scki}};

    always @(negedge scki or posedge cnv) begin
        if (cnv) begin
            kbit = 0;
            frame_tag = frame_tag + 1;
        end else begin
            kbit = kbit + 1;
        end
    end

    always_comb begin
        sdo = '0;
        for (int i = 0; i < N_ADC; i++) sdo[i] = dev_bit(i, kbit, frame_tag);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string p);
        check({p, "_cnv"},    32'(cnv), 0);
        check({p, "_scki"},   32'(scki), 0);
        check({p, "_sdi"},    32'(sdi), 0);
        check({p, "_tvalid"}, 32'(m_tvalid), 0);
        check({p, "_tlast"},  32'(m_tlast), 0);
        check({p, "_tdata"},  m_tdata, 0);
        check({p, "_ovf"},    32'(overflow_cnt), 0);
        check({p, "_active"}, 32'(active), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge tb_ACLK);
        start = 1'b0;
    endtask

    task automatic wait_active(input logic lvl, input int lim,
                               input string tag, output int n);
        n = 0;
        while (active !== lvl && n < lim) begin
            n++;
            @(negedge tb_ACLK);
        end
        if (active !== lvl) check(tag, 32'(active), 32'(lvl));
    endtask

    task automatic watch_frame(output int cw, output int np,
                               output logic [23:0] ss, output int tail);
        logic prev;
        bit done;
        prev = 1'b0;
        done = 1'b0;
        cw = 0;
        np = 0;
        ss = '0;
        tail = 0;
        for (int t = 0; t < 3000 && !done; t++) begin
            if (!active) begin
                done = 1'b1;
            end else begin
                if (cnv) cw++;
                if (scki && !prev) begin
                    if (np < 24) ss = {ss[22:0], sdi};
                    else if (sdi) tail++;
                    np++;
                end
                prev = scki;
                @(negedge tb_ACLK);
            end
        end
        if (!done) check("frame_tmo", 32'(active), 0);
    endtask

    task automatic collect(input int tag, input int mode);
        int j;
        int cyc;
        logic [31:0] held;
        logic [31:0] exp;
        bit stalled;
        j = 0;
        cyc = 0;
        held = '0;
        stalled = 1'b0;
        while (j < BEATS && cyc < 2000) begin
            m_tready = (mode == 0) || (cyc % 3 == 0);
            if (stalled) begin
                check("stall_valid", 32'(m_tvalid), 1);
                check("stall_hold", m_tdata, held);
                stalled = 1'b0;
            end
            if (m_tvalid && m_tready) begin
                exp = {8'(j % N_ADC), dev_word(j % N_ADC, j / N_ADC, tag)};
                check("beat_data", m_tdata, exp);
                check("beat_last", 32'(m_tlast), 32'(j == BEATS - 1));
                j++;
            end else if (m_tvalid) begin
                held = m_tdata;
                stalled = 1'b1;
            end
            cyc++;
            @(negedge tb_ACLK);
        end
        m_tready = 1'b0;
        check("beat_count", 32'(j), 32'(BEATS));
        check("buf_empty", 32'(m_tvalid), 0);
    endtask

    task automatic one_frame(input logic [23:0] ss_in, input string p,
                             input int mode);
        int cw, np, tail;
        logic [23:0] ss;
        softspan = ss_in;
        pulse_start();
        softspan = ~ss_in;
        watch_frame(cw, np, ss, tail);
        check({p, "_cnv_w"}, 32'(cw), 4);
        check({p, "_periods"}, 32'(np), 32'(TOTAL));
        check({p, "_sdi"}, 32'(ss), 32'(ss_in));
        check({p, "_sdi_tail"}, 32'(tail), 0);
        check({p, "_valid"}, 32'(m_tvalid), 1);
        collect(frame_tag, mode);
    endtask

    initial begin
        int n, base, highs;
        ARESET = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        period = 32'd0;
        softspan = '0;
        m_tready = 1'b0;
        repeat (3) @(negedge tb_ACLK);
        check_reset_outs("rst");
        ARESET = 1'b0;
        @(negedge tb_ACLK);

        one_frame(24'hFFFFFF, "f1", 0);
        one_frame(24'h000000, "f2", 0);

        base = frame_tag;
        period = 32'd2000;
        continuous = 1'b1;
        n = 0;
        while (overflow_cnt != 16'd3 && n < 20000) begin
            n++;
            @(negedge tb_ACLK);
        end
        continuous = 1'b0;
        check("ovf_cnt", 32'(overflow_cnt), 3);
        check("ovf_frames", 32'(frame_tag - base), 4);
        repeat (50) @(negedge tb_ACLK);
        check("ovf_idle", 32'(active), 0);
        check("ovf_held", 32'(m_tvalid), 1);
        check("ovf_cnt_hold", 32'(overflow_cnt), 3);
        collect(base + 1, 0);

        one_frame(24'h5A5A5A, "f3", 1);

        pulse_start();
        n = 0;
        while (!scki && n < 200) begin
            n++;
            @(negedge tb_ACLK);
        end
        check("shift_seen", 32'(scki), 1);
        repeat (20) @(negedge tb_ACLK);
        ARESET = 1'b1;
        @(negedge tb_ACLK);
        check_reset_outs("shf_rst");
        ARESET = 1'b0;
        repeat (5) @(negedge tb_ACLK);
        check("shf_rst_idle", 32'(active), 0);

        softspan = 24'h123456;
        pulse_start();
        wait_active(1'b0, 3000, "strm_tmo", n);
        m_tready = 1'b1;
        repeat (10) @(negedge tb_ACLK);
        check("strm_mid", 32'(m_tvalid), 1);
        ARESET = 1'b1;
        m_tready = 1'b0;
        @(negedge tb_ACLK);
        check_reset_outs("strm_rst");
        ARESET = 1'b0;
        repeat (20) @(negedge tb_ACLK);
        check("no_partial", 32'(m_tvalid), 0);

        one_frame(24'hC3A50F, "f4", 0);

        period = 32'd10;
        m_tready = 1'b1;
        continuous = 1'b1;
        wait_active(1'b1, 50, "bb_start", n);
        for (int r = 0; r < 2; r++) begin
            wait_active(1'b0, 3000, "bb_end", n);
            wait_active(1'b1, 100, "bb_restart", n);
            check("bb_idle_dwell", 32'(n), 1);
        end
        continuous = 1'b0;
        wait_active(1'b0, 3000, "stop_end", n);
        highs = 0;
        for (int t = 0; t < 100; t++) begin
            if (active) highs++;
            @(negedge tb_ACLK);
        end
        check("stop_hold_idle", 32'(highs), 0);
        check("bb_no_ovf", 32'(overflow_cnt), 0);
        check("bb_drained", 32'(m_tvalid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
